// File: rtl/acumulador_resultados_pkg.sv
// Shared types, default widths and helpers for the adder-result accumulator.
// Optional feature macro: ACC_SATURA_EN (see acumulador_resultados.sv).
package pkg_acumulador;

    typedef enum logic [1:0] {
        VAZIO      = 2'd0,
        ACUMULANDO = 2'd1,
        CHEIO      = 2'd2
    } estado_t;

    localparam int DEF_BIT      = 8;
    localparam int DEF_ACC_BITS = 16;
    localparam int DEF_CNT_BITS = 8;

    // Accumulator limits for the default accumulator width.
    localparam logic signed [DEF_ACC_BITS-1:0] ACC_MAX = {1'b0, {(DEF_ACC_BITS-1){1'b1}}};
    localparam logic signed [DEF_ACC_BITS-1:0] ACC_MIN = {1'b1, {(DEF_ACC_BITS-1){1'b0}}};

    // Signed add clamped to the range of a 'bits'-wide signed number.
    // Operands are already sign-extended to 32 bits; valid for bits <= 31.
    function automatic logic signed [31:0] sat_add(
        input logic signed [31:0] a,
        input logic signed [31:0] b,
        input int unsigned        bits
    );
        logic signed [32:0] s;
        logic signed [32:0] lim_max;
        logic signed [32:0] lim_min;
        s       = {a[31], a} + {b[31], b};
        lim_max = (33'sd1 <<< (bits - 1)) - 33'sd1;
        lim_min = -(33'sd1 <<< (bits - 1));
        if (s > lim_max) begin
            return lim_max[31:0];
        end else if (s < lim_min) begin
            return lim_min[31:0];
        end
        return s[31:0];
    endfunction

endpackage

// File: rtl/acumulador_resultados_if.sv
// Valid/ready channel carrying one adder result (sum plus its three flags).
interface acumulador_resultados_if
    import pkg_acumulador::*;
#(
    parameter int BIT = DEF_BIT
);
    logic           in_valid;
    logic           in_ready;
    logic [BIT-1:0] sum;
    logic           negativo;
    logic           par;
    logic           zero;

    // Upstream adder side.
    modport master (
        output in_valid, sum, negativo, par, zero,
        input  in_ready
    );

    // Accumulator side.
    modport slave (
        input  in_valid, sum, negativo, par, zero,
        output in_ready
    );
endinterface

// File: rtl/acumulador_resultados_verifica_flags.sv
// Combinational check that the adder flags agree with the sum they came with.
module verifica_flags
    import pkg_acumulador::*;
#(
    parameter int BIT = DEF_BIT
) (
    input  logic [BIT-1:0] sum,
    input  logic           negativo,
    input  logic           par,
    input  logic           zero,
    output logic           erro
);
    // Any flag disagreeing with the value it describes is an error.
    always_comb begin
        erro = (negativo != sum[BIT-1])
            || (par      != ~sum[0])
            || (zero     != (sum == '0));
    end
endmodule

// File: rtl/acumulador_resultados.sv
// Accumulates adder results: running signed sum, per-flag event counters,
// sticky overflow and flag-consistency bits. Stops accepting once the sample
// counter is all-ones, until 'limpa'.
// Macro ACC_SATURA_EN: when defined, the accumulator clamps on overflow
// instead of wrapping (requires ACC_BITS <= 31).
module acumulador_resultados
    import pkg_acumulador::*;
#(
    parameter int BIT      = DEF_BIT,
    parameter int ACC_BITS = DEF_ACC_BITS,
    parameter int CNT_BITS = DEF_CNT_BITS
) (
    input  logic                       clock,
    input  logic                       reset_n,
    acumulador_resultados_if.slave     bus,
    input  logic                       limpa,
    output logic signed [ACC_BITS-1:0] acc_out,
    output logic [CNT_BITS-1:0]        cnt_total,
    output logic [CNT_BITS-1:0]        cnt_neg,
    output logic [CNT_BITS-1:0]        cnt_par,
    output logic [CNT_BITS-1:0]        cnt_zero,
    output logic                       ovf,
    output logic                       erro_flags,
    output logic                       cheio
);
    localparam logic [CNT_BITS-1:0] CNT_UM    = CNT_BITS'(1);
    localparam logic [CNT_BITS-1:0] CNT_TUDO1 = '1;

    estado_t                     estado_reg;
    logic signed [ACC_BITS-1:0]  acc_reg;
    logic signed [ACC_BITS-1:0]  acc_next;
    logic signed [ACC_BITS:0]    soma_ext;
    logic [CNT_BITS-1:0]         cnt_total_reg;
    logic [CNT_BITS-1:0]         cnt_total_next;
    logic                        ovf_reg;
    logic                        erro_reg;
    logic                        cheio_reg;
    logic                        aceita;
    logic                        ovf_amostra;
    logic                        erro_amostra;
    logic [2:0]                  flags_in;

    // Ready drops while full, and also during a clear so a colliding sample is dropped.
    assign bus.in_ready = (estado_reg != CHEIO) && !limpa;
    assign aceita       = bus.in_valid && bus.in_ready;

    verifica_flags #(
        .BIT (BIT)
    ) u_verifica_flags (
        .sum      (bus.sum),
        .negativo (bus.negativo),
        .par      (bus.par),
        .zero     (bus.zero),
        .erro     (erro_amostra)
    );

    // One-bit-wider add: the two top bits differing means signed overflow.
    always_comb begin
        soma_ext       = {acc_reg[ACC_BITS-1], acc_reg}
                       + {{(ACC_BITS+1-BIT){bus.sum[BIT-1]}}, bus.sum};
        ovf_amostra    = soma_ext[ACC_BITS] ^ soma_ext[ACC_BITS-1];
        cnt_total_next = cnt_total_reg + CNT_UM;
`ifdef ACC_SATURA_EN
        acc_next       = ACC_BITS'(sat_add(32'(acc_reg), 32'($signed(bus.sum)), ACC_BITS));
`else
        acc_next       = soma_ext[ACC_BITS-1:0];
`endif
    end

    // Control FSM with accumulator, sample counter and sticky bits.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado_reg    <= VAZIO;
            acc_reg       <= '0;
            cnt_total_reg <= '0;
            ovf_reg       <= 1'b0;
            erro_reg      <= 1'b0;
            cheio_reg     <= 1'b0;
        end else if (limpa) begin
            estado_reg    <= VAZIO;
            acc_reg       <= '0;
            cnt_total_reg <= '0;
            ovf_reg       <= 1'b0;
            erro_reg      <= 1'b0;
            cheio_reg     <= 1'b0;
        end else if (aceita) begin
            acc_reg       <= acc_next;
            cnt_total_reg <= cnt_total_next;
            ovf_reg       <= ovf_reg | ovf_amostra;
            erro_reg      <= erro_reg | erro_amostra;
            if (cnt_total_next == CNT_TUDO1) begin
                estado_reg <= CHEIO;
                cheio_reg  <= 1'b1;
            end else begin
                estado_reg <= ACUMULANDO;
                cheio_reg  <= 1'b0;
            end
        end
    end

    // Flag counters count flags as received; index 0=negativo, 1=par, 2=zero.
    assign flags_in = {bus.zero, bus.par, bus.negativo};

    for (genvar gi = 0; gi < 3; gi++) begin : g_ev
        logic [CNT_BITS-1:0] cnt_reg;

        // Event counter: never exceeds cnt_total, so it cannot wrap.
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                cnt_reg <= '0;
            end else if (limpa) begin
                cnt_reg <= '0;
            end else if (aceita && flags_in[gi]) begin
                cnt_reg <= cnt_reg + CNT_UM;
            end
        end
    end

    assign acc_out    = acc_reg;
    assign cnt_total  = cnt_total_reg;
    assign cnt_neg    = g_ev[0].cnt_reg;
    assign cnt_par    = g_ev[1].cnt_reg;
    assign cnt_zero   = g_ev[2].cnt_reg;
    assign ovf        = ovf_reg;
    assign erro_flags = erro_reg;
    assign cheio      = cheio_reg;

endmodule

// File: tb/tb_acumulador_resultados.sv
// Self-checking bench for acumulador_resultados (BIT=8, ACC_BITS=10, CNT_BITS=3).
// Builds with or without ACC_SATURA_EN; the reference model follows the macro.
module tb_acumulador_resultados;

    localparam int BIT      = 8;
    localparam int ACC_BITS = 10;
    localparam int CNT_BITS = 3;
    localparam int ACC_LIM  = 1 << (ACC_BITS - 1);
    localparam int CNT_MAX  = (1 << CNT_BITS) - 1;

    logic                       clock   = 1'b0;
    logic                       reset_n = 1'b0;
    logic                       limpa   = 1'b0;
    logic signed [ACC_BITS-1:0] acc_out;
    logic [CNT_BITS-1:0]        cnt_total;
    logic [CNT_BITS-1:0]        cnt_neg;
    logic [CNT_BITS-1:0]        cnt_par;
    logic [CNT_BITS-1:0]        cnt_zero;
    logic                       ovf;
    logic                       erro_flags;
    logic                       cheio;

    acumulador_resultados_if #(.BIT(BIT)) bus ();

    acumulador_resultados #(
        .BIT      (BIT),
        .ACC_BITS (ACC_BITS),
        .CNT_BITS (CNT_BITS)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .bus        (bus),
        .limpa      (limpa),
        .acc_out    (acc_out),
        .cnt_total  (cnt_total),
        .cnt_neg    (cnt_neg),
        .cnt_par    (cnt_par),
        .cnt_zero   (cnt_zero),
        .ovf        (ovf),
        .erro_flags (erro_flags),
        .cheio      (cheio)
    );

    always #5 clock = ~clock;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state, plain integers.
    int m_acc  = 0;
    int m_tot  = 0;
    int m_neg  = 0;
    int m_par  = 0;
    int m_zero = 0;
    bit m_ovf  = 0;
    bit m_err  = 0;
    bit m_full = 0;

    task automatic check(input string nome, input int atual, input int esperado);
        n_total++;
        if (atual == esperado) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nome, atual, esperado, $time);
        end
    endtask

    function automatic int s8(input logic [7:0] v);
        return int'($signed(v));
    endfunction

    function automatic bit fora(input int t);
        return (t >= ACC_LIM) || (t < -ACC_LIM);
    endfunction

    // Mathematical sum mapped into the accumulator range.
    function automatic int ajusta(input int t);
        if (!fora(t)) return t;
`ifdef ACC_SATURA_EN
        return (t > 0) ? ACC_LIM - 1 : -ACC_LIM;
`else
        return (((t + ACC_LIM) % (2 * ACC_LIM)) + 2 * ACC_LIM) % (2 * ACC_LIM) - ACC_LIM;
`endif
    endfunction

    function automatic bit flags_ruins(input int s, input logic n, input logic p, input logic z);
        return (n != (s < 0)) || (p != (s % 2 == 0)) || (z != (s == 0));
    endfunction

    // Model: a sample is taken when valid, not full and not clearing.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n || limpa) begin
            m_acc  <= 0;
            m_tot  <= 0;
            m_neg  <= 0;
            m_par  <= 0;
            m_zero <= 0;
            m_ovf  <= 0;
            m_err  <= 0;
            m_full <= 0;
        end else if (bus.in_valid && !m_full) begin
            m_acc  <= ajusta(m_acc + s8(bus.sum));
            m_ovf  <= m_ovf || fora(m_acc + s8(bus.sum));
            m_err  <= m_err || flags_ruins(s8(bus.sum), bus.negativo, bus.par, bus.zero);
            m_tot  <= m_tot + 1;
            m_neg  <= m_neg + int'(bus.negativo);
            m_par  <= m_par + int'(bus.par);
            m_zero <= m_zero + int'(bus.zero);
            m_full <= (m_tot + 1 == CNT_MAX);
            $display("tx sum=%0d neg=%0b par=%0b zero=%0b acc_before=%0d count_before=%0d",
                     s8(bus.sum), bus.negativo, bus.par, bus.zero, m_acc, m_tot);
        end
    end

    // Every cycle: all DUT outputs against the model.
    always @(negedge clock) begin
        check("acc_out",    int'(acc_out),    m_acc);
        check("cnt_total",  int'(cnt_total),  m_tot);
        check("cnt_neg",    int'(cnt_neg),    m_neg);
        check("cnt_par",    int'(cnt_par),    m_par);
        check("cnt_zero",   int'(cnt_zero),   m_zero);
        check("ovf",        int'(ovf),        int'(m_ovf));
        check("erro_flags", int'(erro_flags), int'(m_err));
        check("cheio",      int'(cheio),      int'(m_full));
        check("in_ready",   int'(bus.in_ready), int'(!m_full && !limpa));
    end

    task automatic ciclo(input bit v, input logic [7:0] s, input bit n, input bit p,
                         input bit z, input bit l);
        bus.in_valid = v;
        bus.sum      = s;
        bus.negativo = n;
        bus.par      = p;
        bus.zero     = z;
        limpa        = l;
        @(posedge clock);
        #1;
    endtask

    task automatic enviar(input logic [7:0] s);
        ciclo(1'b1, s, s[7], ~s[0], s == 8'd0, 1'b0);
    endtask

    task automatic ocioso();
        ciclo(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.sum      = '0;
        bus.negativo = 1'b0;
        bus.par      = 1'b0;
        bus.zero     = 1'b0;

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        check("rst_acc",     int'(acc_out),      0);
        check("rst_total",   int'(cnt_total),    0);
        check("rst_in_ready", int'(bus.in_ready), 1);
        check("rst_cheio",   int'(cheio),        0);
        reset_n = 1'b1;
        ocioso();

        // -3 then 4 with correct flags
        enviar(8'hFD);
        enviar(8'd4);
        check("t2_acc",   int'(acc_out),    1);
        check("t2_total", int'(cnt_total),  2);
        check("t2_neg",   int'(cnt_neg),    1);
        check("t2_par",   int'(cnt_par),    1);
        check("t2_erro",  int'(erro_flags), 0);
        ocioso();

        // Odd sum flagged even
        ciclo(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        ciclo(1'b1, 8'd5, 1'b0, 1'b1, 1'b0, 1'b0);
        check("t3_erro", int'(erro_flags), 1);
        check("t3_par",  int'(cnt_par),    1);
        ocioso();
        ocioso();
        check("t3_erro_sticky", int'(erro_flags), 1);

        // Clear colliding with a valid sample
        bus.in_valid = 1'b1;
        bus.sum      = 8'd9;
        bus.negativo = 1'b0;
        bus.par      = 1'b0;
        bus.zero     = 1'b0;
        limpa        = 1'b1;
        #1;
        check("t6_in_ready", int'(bus.in_ready), 0);
        @(posedge clock);
        #1;
        check("t6_total", int'(cnt_total),  0);
        check("t6_acc",   int'(acc_out),    0);
        check("t6_erro",  int'(erro_flags), 0);

        // Accumulator overflow: 5 x 127 = 635
        for (int i = 0; i < 5; i++) enviar(8'd127);
`ifdef ACC_SATURA_EN
        check("t4_acc_sat", int'(acc_out), 511);
`else
        check("t4_acc_wrap", int'(acc_out), -389);
`endif
        check("t4_ovf", int'(ovf), 1);

        // Fill the sample counter
        ciclo(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) enviar(8'd1);
        check("t5_cheio",    int'(cheio),        1);
        check("t5_in_ready", int'(bus.in_ready), 0);
        enviar(8'd1);
        check("t5_total_hold", int'(cnt_total), 7);
        check("t5_acc_hold",   int'(acc_out),   7);
        ciclo(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        ocioso();
        check("t5_clr_total", int'(cnt_total),    0);
        check("t5_clr_cheio", int'(cheio),        0);
        check("t5_clr_ready", int'(bus.in_ready), 1);

        // Reset mid-stream: outputs clear before the next edge
        enviar(8'd20);
        enviar(8'hF0);
        #3;
        reset_n = 1'b0;
        #1;
        check("t1_acc",   int'(acc_out),        0);
        check("t1_total", int'(cnt_total),      0);
        check("t1_neg",   int'(cnt_neg),        0);
        check("t1_ready", int'(bus.in_ready),   1);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        ocioso();

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            logic [7:0] s;
            logic [2:0] f;
            bit         v;
            bit         l;
            v = ($urandom_range(0, 9) < 7);
            l = ($urandom_range(0, 11) == 0);
            case ($urandom_range(0, 4))
                0:       s = 8'h7F;
                1:       s = 8'h80;
                2:       s = 8'h00;
                default: s = 8'($urandom);
            endcase
            f = {s[7], ~s[0], s == 8'd0};
            if ($urandom_range(0, 9) == 0) f = 3'($urandom);
            ciclo(v, s, f[2], f[1], f[0], l);
        end
        ocioso();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
